// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell reused over WIDTH clocks, LSB first.
// Optional signed-overflow output OVF is built when SERIAL_ADD_OVF_EN is defined.
module serial_add_seq #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_nx_s;
    logic [WIDTH-1:0] sum_r;
    logic [CW-1:0]    cnt_r;
    logic             c_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;
    logic             load_s;
    logic             step_s;
    logic             finish_s;
    logic             s_bit_s;
    logic             c_nx_s;

    function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
        full_add = {(x & y) | (y & ci) | (ci & x), x ^ y ^ ci};
    endfunction

    // The A register doubles as the result register: sum bits enter at the MSB as A drains.
    if (WIDTH == 1) begin : g_w1
        assign a_nx_s = s_bit_s;
    end else begin : g_wn
        assign a_nx_s = {s_bit_s, a_r[WIDTH-1:1]};
    end

    // Next-state and control decode
    always_comb begin
        state_nx_s        = state_r;
        load_s            = 1'b0;
        step_s            = 1'b0;
        finish_s          = 1'b0;
        {c_nx_s, s_bit_s} = full_add(a_r[0], b_r[0], c_r);
        case (state_r)
            S_IDLE, S_DONE: begin
                if (START) begin
                    state_nx_s = S_RUN;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                step_s = 1'b1;
                if (cnt_r == LAST) begin
                    state_nx_s = S_DONE;
                    finish_s   = 1'b1;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            default: begin
                state_nx_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= S_IDLE;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == S_RUN);
            done_r  <= (state_nx_s == S_DONE);
            if (load_s) begin
                a_r   <= A;
                b_r   <= B;
                c_r   <= CIN;
                cnt_r <= {CW{1'b0}};
            end else if (step_s) begin
                a_r   <= a_nx_s;
                b_r   <= b_r >> 1'b1;
                c_r   <= c_nx_s;
                cnt_r <= cnt_r + CW'(1);
            end
            if (finish_s) begin
                sum_r  <= a_nx_s;
                cout_r <= c_nx_s;
            end
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    logic ovf_r;

    // Carry into the MSB is still in c_r on the final edge; XOR with carry out gives signed overflow.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ovf_r <= 1'b0;
        end else if (finish_s) begin
            ovf_r <= c_r ^ c_nx_s;
        end
    end

    assign OVF = ovf_r;
`endif

    assign BUSY = busy_r;
    assign DONE = done_r;
    assign SUM  = sum_r;
    assign COUT = cout_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench: WIDTH=4, 1 and 8 instances share stimulus and are checked against
// an arithmetic reference model ({COUT,SUM} = A+B+CIN; OVF from operand/result signs).
module tb_serial_add_seq;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b1;
    logic       START = 1'b0;
    logic       CIN   = 1'b0;
    logic [7:0] A     = 8'h00;
    logic [7:0] B     = 8'h00;

    logic       BUSY4, DONE4, COUT4;
    logic [3:0] SUM4;
    logic       BUSY1, DONE1, COUT1;
    logic [0:0] SUM1;
    logic       BUSY8, DONE8, COUT8;
    logic [7:0] SUM8;
`ifdef SERIAL_ADD_OVF_EN
    logic       OVF4, OVF1, OVF8;
`endif

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    serial_add_seq #(.WIDTH(4)) u4 (
        .CLK(CLK), .RST(RST), .START(START), .A(A[3:0]), .B(B[3:0]), .CIN(CIN),
        .BUSY(BUSY4), .DONE(DONE4), .SUM(SUM4), .COUT(COUT4)
`ifdef SERIAL_ADD_OVF_EN
        , .OVF(OVF4)
`endif
    );

    serial_add_seq #(.WIDTH(1)) u1 (
        .CLK(CLK), .RST(RST), .START(START), .A(A[0:0]), .B(B[0:0]), .CIN(CIN),
        .BUSY(BUSY1), .DONE(DONE1), .SUM(SUM1), .COUT(COUT1)
`ifdef SERIAL_ADD_OVF_EN
        , .OVF(OVF1)
`endif
    );

    serial_add_seq #(.WIDTH(8)) u8 (
        .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .CIN(CIN),
        .BUSY(BUSY8), .DONE(DONE8), .SUM(SUM8), .COUT(COUT8)
`ifdef SERIAL_ADD_OVF_EN
        , .OVF(OVF8)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] add_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic c, input int w);
        logic [9:0] mask_in;
        logic [9:0] mask_out;
        logic [9:0] tot;
        mask_in  = (10'd1 << w) - 10'd1;
        mask_out = (10'd1 << (w + 1)) - 10'd1;
        tot      = {2'b00, a & mask_in[7:0]} + {2'b00, b & mask_in[7:0]} + {9'd0, c};
        tot      = tot & mask_out;
        return tot[8:0];
    endfunction

    function automatic logic ovf_ref(input logic [7:0] a, input logic [7:0] b,
                                     input logic c, input int w);
        logic [8:0] s;
        s = add_ref(a, b, c, w);
        return (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    endfunction

    // One transaction on all three instances; optionally re-pulses START mid-run.
    task automatic run_all(input logic [7:0] a, input logic [7:0] b, input logic c,
                           input bit inject, input string tag,
                           output logic [4:0] r4, output logic o4);
        int         lat1, lat4, lat8, n1, n4, n8, busy4;
        logic       stable4;
        logic [3:0] prev4;
        logic [8:0] g1, g4, g8;
        logic       v1, v4, v8;
        lat1 = -1; lat4 = -1; lat8 = -1; n1 = 0; n4 = 0; n8 = 0; busy4 = 0;
        stable4 = 1'b1;
        g1 = 9'd0; g4 = 9'd0; g8 = 9'd0; v1 = 1'b0; v4 = 1'b0; v8 = 1'b0;
        @(negedge CLK);
        prev4 = SUM4;
        A = a; B = b; CIN = c; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        A = 8'($urandom); B = 8'($urandom); CIN = 1'($urandom);
        for (int k = 0; k < 11; k++) begin
            if (inject && k == 2) begin
                A = 8'hFF; B = 8'hFF; CIN = 1'b1; START = 1'b1;
            end else begin
                START = 1'b0;
            end
            if (BUSY4) busy4++;
            if (DONE4) begin
                n4++;
                if (lat4 < 0) begin
                    lat4 = k; g4 = {4'd0, COUT4, SUM4};
`ifdef SERIAL_ADD_OVF_EN
                    v4 = OVF4;
`endif
                end
            end else if (lat4 < 0 && SUM4 !== prev4) begin
                stable4 = 1'b0;
            end
            if (DONE1) begin
                n1++;
                if (lat1 < 0) begin
                    lat1 = k; g1 = {7'd0, COUT1, SUM1};
`ifdef SERIAL_ADD_OVF_EN
                    v1 = OVF1;
`endif
                end
            end
            if (DONE8) begin
                n8++;
                if (lat8 < 0) begin
                    lat8 = k; g8 = {COUT8, SUM8};
`ifdef SERIAL_ADD_OVF_EN
                    v8 = OVF8;
`endif
                end
            end
            @(negedge CLK);
        end
        START = 1'b0;
        chk({tag, " w4 latency"}, lat4, 32'd4);
        chk({tag, " w4 busy cycles"}, busy4, 32'd4);
        chk({tag, " w4 done pulses"}, n4, 32'd1);
        chk({tag, " w4 sum held"}, {31'd0, stable4}, 32'd1);
        chk({tag, " w4 result"}, {23'd0, g4}, {23'd0, add_ref(a, b, c, 4)});
        chk({tag, " w8 latency"}, lat8, 32'd8);
        chk({tag, " w8 done pulses"}, n8, 32'd1);
        chk({tag, " w8 result"}, {23'd0, g8}, {23'd0, add_ref(a, b, c, 8)});
        if (!inject) begin
            chk({tag, " w1 latency"}, lat1, 32'd1);
            chk({tag, " w1 result"}, {23'd0, g1}, {23'd0, add_ref(a, b, c, 1)});
        end
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, " w4 ovf"}, {31'd0, v4}, {31'd0, ovf_ref(a, b, c, 4)});
        chk({tag, " w8 ovf"}, {31'd0, v8}, {31'd0, ovf_ref(a, b, c, 8)});
        if (!inject) chk({tag, " w1 ovf"}, {31'd0, v1}, {31'd0, ovf_ref(a, b, c, 1)});
`endif
        r4 = g4[4:0];
        o4 = v4;
    endtask

    initial begin
        logic [4:0] r;
        logic       o;
        logic [7:0] hi;
        int         dones, idle, lastd;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset w4 outs", {26'd0, BUSY4, DONE4, COUT4, SUM4}, 32'd0);
        chk("reset w1 outs", {28'd0, BUSY1, DONE1, COUT1, SUM1}, 32'd0);
        chk("reset w8 outs", {21'd0, BUSY8, DONE8, COUT8, SUM8}, 32'd0);
        RST = 1'b0;

        // Directed arithmetic
        run_all(8'h07, 8'h09, 1'b0, 1'b0, "7+9", r, o);
        chk("7+9 const", {27'd0, r}, 32'h10);
        run_all(8'h0F, 8'h0F, 1'b1, 1'b0, "F+F+1", r, o);
        chk("F+F+1 const", {27'd0, r}, 32'h1F);
        run_all(8'h03, 8'h04, 1'b0, 1'b0, "3+4", r, o);
        chk("3+4 const", {27'd0, r}, 32'h07);

        // START during RUN is ignored
        run_all(8'h05, 8'h06, 1'b0, 1'b1, "ignored start", r, o);
        chk("ignored start const", {27'd0, r}, 32'h0B);

`ifdef SERIAL_ADD_OVF_EN
        run_all(8'h07, 8'h01, 1'b0, 1'b0, "ovf 7+1", r, o);
        chk("ovf 7+1 const", {26'd0, o, r}, {26'd0, 1'b1, 5'h08});
        run_all(8'h08, 8'h08, 1'b0, 1'b0, "ovf 8+8", r, o);
        chk("ovf 8+8 const", {26'd0, o, r}, {26'd0, 1'b1, 5'h10});
        run_all(8'h02, 8'h03, 1'b0, 1'b0, "ovf 2+3", r, o);
        chk("ovf 2+3 const", {26'd0, o, r}, {26'd0, 1'b0, 5'h05});
`endif

        // START held high: back-to-back runs every WIDTH+1 cycles
        @(negedge CLK);
        A = 8'h01; B = 8'h01; CIN = 1'b0; START = 1'b1;
        dones = 0; idle = 0; lastd = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (DONE4) begin
                dones++;
                chk("b2b sum", {27'd0, COUT4, SUM4}, 32'h02);
                if (lastd >= 0) chk("b2b period", k - lastd, 32'd5);
                lastd = k;
            end else if (!BUSY4) begin
                idle++;
            end
        end
        START = 1'b0;
        chk("b2b done count", dones, 32'd4);
        chk("b2b idle cycles", idle, 32'd0);
        repeat (12) @(negedge CLK);

        // Reset in the second RUN cycle aborts the run
        A = 8'h09; B = 8'h09; CIN = 1'b0; START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort outs", {26'd0, BUSY4, DONE4, COUT4, SUM4}, 32'd0);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (DONE4) dones++;
        end
        chk("abort no done", dones, 32'd0);
        run_all(8'h02, 8'h03, 1'b1, 1'b0, "after abort", r, o);
        chk("after abort const", {27'd0, r}, 32'h06);

        // Every WIDTH=4 operand/CIN combination; random upper bits exercise WIDTH=8
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                for (int c = 0; c < 2; c++) begin
                    hi = 8'($urandom);
                    run_all({hi[3:0], 4'(a)}, {hi[7:4], 4'(b)}, 1'(c), 1'b0, "sweep", r, o);
                end
            end
        end

        // Fully random WIDTH=8 operands
        for (int i = 0; i < 60; i++) begin
            run_all(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, "random", r, o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial adder sequencer: one full-adder cell, reused over WIDTH cycles, adds two WIDTH-bit operands LSB first.
- Sits where the 4-bit ripple adder sits when area beats latency.
- Captures operands on START, runs one bit per clock, then presents SUM/COUT with a one-cycle DONE pulse.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 1..32.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only in IDLE or DONE.
- A  input  WIDTH  operand A; captured on accepted START.
- B  input  WIDTH  operand B; captured on accepted START.
- CIN  input  1  carry-in; captured on accepted START.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; SUM/COUT valid.
- SUM  output  WIDTH  result; holds last completed sum.
- COUT  output  1  carry-out of last completed addition.

Behaviour:
- Reset (RST sampled high): state IDLE, BUSY=0, DONE=0, SUM=0, COUT=0; internal shift registers, carry FF and counter cleared. RST has priority over START.
- States and transitions:
  - IDLE: START=1 -> RUN. On that edge, capture A/B into shift registers, CIN into carry FF, and clear the bit counter. Otherwise stay in IDLE.
  - RUN: each edge processes bit[cnt].
    - s = a0 ^ b0 ^ c; c' = a0&b0 | b0&c | c&a0.
    - Shift A/B right by one; shift s into the result register from the MSB side; carry FF <= c'; cnt <= cnt+1.
    - On the edge where cnt == WIDTH-1: go to DONE, write SUM <= full result and COUT <= c'.
  - DONE: DONE=1 for exactly one cycle.
    - START=1 -> RUN with new operands captured (back-to-back, no idle bubble).
    - Otherwise -> IDLE.
- BUSY = (state == RUN). START during RUN is ignored and not queued.
- Latency: START sampled at edge 0 -> bits processed at edges 1..WIDTH -> DONE high in the cycle after edge WIDTH. Throughput is one result per WIDTH+1 cycles.
- SUM/COUT change only on the RUN->DONE edge; they never show partial results and hold until the next completion or reset.
- A/B/CIN may change freely after the accepting edge.
- Counter width max(1, clog2(WIDTH)).
- WIDTH=1: a single RUN cycle, then DONE.
- Arithmetic: {COUT,SUM} == A + B + CIN, modulo 2^(WIDTH+1); unsigned.
- Reset mid-RUN: abort with no DONE pulse; SUM/COUT forced to 0.

Optional Feature:
- Macro SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output OVF (1 bit) = carry into MSB XOR carry out of MSB, i.e. two's-complement signed overflow.
  - Registered alongside SUM on the RUN->DONE edge; reset 0; held like SUM.
  - Requires an internal FF capturing the carry before the final bit.
- Not defined: no OVF port and no extra logic; all other behaviour identical.

Test Plan:
- Reset, then WIDTH=4, A=0x7, B=0x9, CIN=0, START one cycle -> BUSY high 4 cycles, DONE pulse after edge 4, SUM=0x0, COUT=1; SUM stays 0 during RUN.
- A=0xF, B=0xF, CIN=1 -> SUM=0xF, COUT=1. Then A=0x3, B=0x4, CIN=0 -> SUM=0x7, COUT=0.
- Change A/B and pulse START during RUN -> ignored; result matches the originally captured operands, and only one DONE pulse.
- Hold START high with A=0x1, B=0x1 continuously -> DONE every 5 cycles, no IDLE cycle between runs, each SUM=0x2.
- Assert RST at the 2nd RUN cycle -> no DONE; SUM=0, COUT=0, BUSY=0 next cycle; a new START afterwards completes normally.
- With SERIAL_ADD_OVF_EN defined, A=0x7, B=0x1, CIN=0 -> SUM=0x8, COUT=0, OVF=1; A=0x8, B=0x8 -> SUM=0x0, COUT=1, OVF=1; A=0x2, B=0x3 -> OVF=0.
- Randomized: all WIDTH=4 operand/CIN combinations compared against A+B+CIN, also run at WIDTH=1 and WIDTH=8.
